// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable controller: halt / divided run / single-step / run-to-breakpoint, one clk_ce pulse per CPU cycle.
// cpu_ce and cyc_cnt are registered (one clk after the tick decision); no backpressure, pulses are never queued.
module cpu_clk_ctrl #(
    parameter int DIV_W  = 16,
    parameter int CNT_W  = 32,
    parameter int MODE_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [MODE_W-1:0] mode,
    input  logic [DIV_W-1:0]  div,
    input  logic              step_req,
    input  logic [CNT_W-1:0]  brk_cnt,
    input  logic              clr_cnt,
    output logic              cpu_ce,
    output logic [CNT_W-1:0]  cyc_cnt,
    output logic              halted,
    output logic              brk_hit
);

    localparam logic [MODE_W-1:0] MODE_HALT = MODE_W'(0);
    localparam logic [MODE_W-1:0] MODE_RUN  = MODE_W'(1);
    localparam logic [MODE_W-1:0] MODE_STEP = MODE_W'(2);
    localparam logic [MODE_W-1:0] MODE_BRK  = MODE_W'(3);

    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2,
        S_BRK  = 2'd3
    } state_t;

    state_t              r_state;
    logic [DIV_W-1:0]    r_div_cnt;
    logic                r_step_prev;
    logic                r_cpu_ce;
    logic [CNT_W-1:0]    r_cyc_cnt;
    logic                r_brk_hit;

    logic                w_run_tick;
    logic                w_step_tick;
    logic                w_tick;
    logic                w_div_wrap;
    logic [CNT_W-1:0]    w_cyc_inc;
    logic                w_brk_now;

    // A shrunken div below the current count also lands here, wrapping without a tick.
    assign w_div_wrap  = (r_div_cnt >= div);
    assign w_run_tick  = (r_state == S_RUN) && (r_div_cnt == div);
    assign w_step_tick = (r_state == S_STEP) && step_req && !r_step_prev;
    assign w_tick      = w_run_tick || w_step_tick;
    assign w_cyc_inc   = r_cyc_cnt + CNT_W'(1);
    assign w_brk_now   = w_run_tick && (mode == MODE_BRK) && (w_cyc_inc == brk_cnt) && !clr_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_HALT;
            r_div_cnt   <= '0;
            r_step_prev <= 1'b0;
            r_cpu_ce    <= 1'b0;
            r_cyc_cnt   <= '0;
            r_brk_hit   <= 1'b0;
        end else begin
            r_step_prev <= step_req;
            r_cpu_ce    <= w_tick;

            if (clr_cnt) begin
                r_cyc_cnt <= '0;
            end else if (w_tick) begin
                r_cyc_cnt <= w_cyc_inc;
            end

            if (clr_cnt || (mode != MODE_BRK)) begin
                r_brk_hit <= 1'b0;
            end else if (w_brk_now) begin
                r_brk_hit <= 1'b1;
            end

            if ((r_state != S_RUN) || w_div_wrap) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end

            // BRK is only left by a clear or by moving off the run-to-break mode.
            case (mode)
                MODE_HALT: r_state <= S_HALT;
                MODE_RUN:  r_state <= S_RUN;
                MODE_STEP: r_state <= S_STEP;
                default: begin
                    if ((r_state == S_BRK) && !clr_cnt) begin
                        r_state <= S_BRK;
                    end else if (w_brk_now) begin
                        r_state <= S_BRK;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
            endcase
        end
    end

    assign cpu_ce  = r_cpu_ce;
    assign cyc_cnt = r_cyc_cnt;
    assign brk_hit = r_brk_hit;
    assign halted  = (r_state == S_HALT) || (r_state == S_BRK) ||
                     ((r_state == S_STEP) && !r_cpu_ce);

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed bench for cpu_clk_ctrl: a default-width instance plus a 4-bit counter instance for wrap checks.
module tb_cpu_clk_ctrl;

    logic        clk;
    logic        rst_n;
    logic [1:0]  mode;
    logic [15:0] div;
    logic        step_req;
    logic [31:0] brk_cnt;
    logic        clr_cnt;

    logic        cpu_ce;
    logic [31:0] cyc_cnt;
    logic        halted;
    logic        brk_hit;

    logic        n_cpu_ce;
    logic [3:0]  n_cyc_cnt;
    logic        n_halted;
    logic        n_brk_hit;

    int n_tests;
    int n_fail;

    cpu_clk_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .div      (div),
        .step_req (step_req),
        .brk_cnt  (brk_cnt),
        .clr_cnt  (clr_cnt),
        .cpu_ce   (cpu_ce),
        .cyc_cnt  (cyc_cnt),
        .halted   (halted),
        .brk_hit  (brk_hit)
    );

    cpu_clk_ctrl #(.CNT_W(4)) dut_n (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .div      (div),
        .step_req (step_req),
        .brk_cnt  (brk_cnt[3:0]),
        .clr_cnt  (clr_cnt),
        .cpu_ce   (n_cpu_ce),
        .cyc_cnt  (n_cyc_cnt),
        .halted   (n_halted),
        .brk_hit  (n_brk_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int       cnt;
        int       pos_err;
        int       consec;
        int       n_miss;
        logic     prev;
        logic     wrapped;
        logic     found;
        logic [3:0] prevn;
        logic [3:0] pat;

        n_tests = 0;
        n_fail  = 0;

        rst_n = 1'b0; mode = 2'b01; div = 16'd0; step_req = 1'b0; brk_cnt = 32'd0; clr_cnt = 1'b0;
        cyc(3);
        check("reset_ce",     64'(cpu_ce),  64'd0);
        check("reset_cyc",    64'(cyc_cnt), 64'd0);
        check("reset_halted", 64'(halted),  64'd1);
        check("reset_brk",    64'(brk_hit), 64'd0);

        rst_n = 1'b1;
        cyc(1);
        check("run_entry_ce",     64'(cpu_ce), 64'd0);
        check("run_entry_halted", 64'(halted), 64'd0);
        cyc(1);
        check("first_ce",  64'(cpu_ce),  64'd1);
        check("first_cyc", 64'(cyc_cnt), 64'd1);
        cyc(1);
        check("div0_ce",  64'(cpu_ce),  64'd1);
        check("div0_cyc", 64'(cyc_cnt), 64'd2);

        // clear wins over the increment but the pulse is still issued
        mode = 2'b00; clr_cnt = 1'b1;
        cyc(1);
        clr_cnt = 1'b0;
        check("clr_pulse_kept", 64'(cpu_ce),  64'd1);
        check("clr_cyc",        64'(cyc_cnt), 64'd0);
        cyc(1);
        check("halt_ce",     64'(cpu_ce), 64'd0);
        check("halt_halted", 64'(halted), 64'd1);

        mode = 2'b01; div = 16'd3;
        cyc(1);
        cnt = 0; pos_err = 0; consec = 0; prev = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            cyc(1);
            if (cpu_ce) cnt++;
            if (cpu_ce !== (k % 4 == 0)) pos_err++;
            if (cpu_ce && prev) consec++;
            prev = cpu_ce;
        end
        check("div3_pulses",    64'(cnt),     64'd10);
        check("div3_cyc",       64'(cyc_cnt), 64'd10);
        check("div3_positions", 64'(pos_err), 64'd0);
        check("div3_consec",    64'(consec),  64'd0);

        // div_cnt is 2 when div drops to 1: wrap with no tick, then tick two clk later
        cyc(2);
        div = 16'd1;
        pat = 4'd0;
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            pat = {pat[2:0], cpu_ce};
        end
        check("divchg_pattern", 64'(pat),     64'h1);
        check("divchg_cyc",     64'(cyc_cnt), 64'd11);

        mode = 2'b00; clr_cnt = 1'b1;
        cyc(2);
        clr_cnt = 1'b0;
        check("step_pre_cyc", 64'(cyc_cnt), 64'd0);
        mode = 2'b10;
        cyc(1);
        check("step_idle_halted", 64'(halted), 64'd1);
        cnt = 0; pos_err = 0;
        for (int s = 0; s < 3; s++) begin
            step_req = 1'b1;
            for (int k = 0; k < 8; k++) begin
                cyc(1);
                if (cpu_ce) cnt++;
                if (cpu_ce !== (k == 0)) pos_err++;
                if (s == 0 && k == 0) check("step_pulse_halted", 64'(halted), 64'd0);
                if (k == 4) step_req = 1'b0;
            end
        end
        check("step_pulses",    64'(cnt),     64'd3);
        check("step_positions", 64'(pos_err), 64'd0);
        check("step_cyc",       64'(cyc_cnt), 64'd3);

        // a rise seen in HALT is dropped, and still-high step_req in STEP is not a new edge
        mode = 2'b00;
        cyc(1);
        step_req = 1'b1;
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            if (cpu_ce) cnt++;
        end
        mode = 2'b10;
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            if (cpu_ce) cnt++;
        end
        check("halt_step_pulses", 64'(cnt),     64'd0);
        check("halt_step_cyc",    64'(cyc_cnt), 64'd3);
        step_req = 1'b0;

        mode = 2'b00; clr_cnt = 1'b1;
        cyc(1);
        clr_cnt = 1'b0;
        mode = 2'b11; div = 16'd0; brk_cnt = 32'd7;
        cyc(1);
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            cyc(1);
            if (cpu_ce) cnt++;
        end
        check("brk_pulses", 64'(cnt),     64'd7);
        check("brk_hit",    64'(brk_hit), 64'd1);
        check("brk_halted", 64'(halted),  64'd1);
        check("brk_cyc",    64'(cyc_cnt), 64'd7);

        clr_cnt = 1'b1;
        cyc(1);
        clr_cnt = 1'b0;
        check("brkclr_hit", 64'(brk_hit), 64'd0);
        check("brkclr_cyc", 64'(cyc_cnt), 64'd0);
        check("brkclr_ce",  64'(cpu_ce),  64'd0);
        cyc(1);
        check("resume_ce",  64'(cpu_ce),  64'd1);
        check("resume_cyc", 64'(cyc_cnt), 64'd1);

        cyc(5);
        check("pre_sim_cyc", 64'(cyc_cnt), 64'd6);
        clr_cnt = 1'b1;
        cyc(1);
        clr_cnt = 1'b0;
        check("sim_brk_hit", 64'(brk_hit), 64'd0);
        check("sim_cyc",     64'(cyc_cnt), 64'd0);
        check("sim_halted",  64'(halted),  64'd0);
        check("sim_ce",      64'(cpu_ce),  64'd1);

        mode = 2'b01; clr_cnt = 1'b1;
        cyc(1);
        clr_cnt = 1'b0;
        check("wrap_start", 64'(n_cyc_cnt), 64'd0);
        wrapped = 1'b0; prevn = 4'd0; n_miss = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc(1);
            if (prevn == 4'd15 && n_cyc_cnt == 4'd0) wrapped = 1'b1;
            prevn = n_cyc_cnt;
            if (!n_cpu_ce) n_miss++;
        end
        check("wrap_seen",     64'(wrapped),   64'd1);
        check("wrap_final",    64'(n_cyc_cnt), 64'd4);
        check("wide_final",    64'(cyc_cnt),   64'd20);
        check("wrap_ce_every", 64'(n_miss),    64'd0);
        check("wrap_brk",      64'(n_brk_hit), 64'd0);
        check("wrap_halted",   64'(n_halted),  64'd0);

        div = 16'd2;
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc(1);
            if (cpu_ce) begin
                found = 1'b1;
                break;
            end
        end
        check("midrst_found", 64'(found), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ce",     64'(cpu_ce),  64'd0);
        check("midrst_cyc",    64'(cyc_cnt), 64'd0);
        check("midrst_halted", 64'(halted),  64'd1);
        cyc(1);
        rst_n = 1'b1;
        pat = 4'd0;
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            pat = {pat[2:0], cpu_ce};
        end
        check("midrst_pattern", 64'(pat),     64'h1);
        check("midrst_cyc1",    64'(cyc_cnt), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
